// File: rtl/fdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdu_pkg
// Description : Shared definitions for the fault detection unit: per-unit
//               recovery state encodings, unit count, counter widths and a
//               lowest-index priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fdu_pkg;

    localparam int N_UNITS = 3;
    localparam int CNT_W   = 24;
    localparam int SEL_W   = 2;

    // Per-unit recovery FSM encodings
    localparam logic [2:0] ST_WAIT_UP   = 3'd0;
    localparam logic [2:0] ST_QUALIFY   = 3'd1;
    localparam logic [2:0] ST_READY     = 3'd2;
    localparam logic [2:0] ST_RESETTING = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;

    // Index of the lowest set bit; 0 when the vector is empty
    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_UNITS-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unit_recovery.sv
`default_nettype none
// ============================================================================
// Module      : unit_recovery
// Description : Qualification and recovery sequencer for one redundant unit.
//               Tracks watchdog health, qualifies the unit after HOLDOFF
//               healthy samples, issues RESET_CYCLES-wide recovery resets and
//               locks the unit out after repeated failures.
//               Config macro FAILOVER_AUTO_RECOVER_EN: when defined, faults
//               retry through a recovery reset and WAIT_UP times out; when
//               undefined, every fault locks the unit.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_recovery
    import fdu_pkg::*;
#(
    parameter int unsigned HOLDOFF      = 1000,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned UP_TIMEOUT   = 13000000,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic health,
    input  logic lock_clear,
    output logic unit_reset,
    output logic ready,
    output logic locked
);

    localparam int c_RETRY_W = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;

    localparam logic [CNT_W:0]         c_HOLDOFF     = (CNT_W + 1)'(HOLDOFF);
    localparam logic [CNT_W:0]         c_RESET_CYC   = (CNT_W + 1)'(RESET_CYCLES);
    localparam logic [CNT_W:0]         c_UP_TIMEOUT  = (CNT_W + 1)'(UP_TIMEOUT);
    localparam logic [c_RETRY_W-1:0]   c_MAX_RETRIES = c_RETRY_W'(MAX_RETRIES);

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_RETRY_W-1:0] r_retries;

    logic [2:0]           w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [c_RETRY_W-1:0] w_retries_nxt;
    logic [CNT_W:0]       w_cnt_inc;
    logic                 w_fault;

    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    // Next-state, counter and retry bookkeeping for the unit
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_fault       = 1'b0;

        case (r_state)
            ST_WAIT_UP: begin
                if (health) begin
                    if (HOLDOFF <= 1) begin
                        w_state_nxt = ST_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_QUALIFY;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else begin
                    // Saturate at the timeout so the count never wraps
                    if (w_cnt_inc <= c_UP_TIMEOUT) begin
                        w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    end
`ifdef FAILOVER_AUTO_RECOVER_EN
                    if (w_cnt_inc >= c_UP_TIMEOUT) begin
                        w_fault = 1'b1;
                    end
`endif
                end
            end
            ST_QUALIFY: begin
                if (!health) begin
                    w_state_nxt = ST_WAIT_UP;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc >= c_HOLDOFF) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[CNT_W-1:0];
                end
            end
            ST_READY: begin
                if (!health) begin
                    w_fault = 1'b1;
                end
            end
            ST_RESETTING: begin
                if (w_cnt_inc >= c_RESET_CYC) begin
                    w_state_nxt = ST_WAIT_UP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc[CNT_W-1:0];
                end
            end
            ST_LOCKED: begin
                if (lock_clear) begin
                    w_state_nxt   = ST_RESETTING;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_UP;
                w_cnt_nxt   = '0;
            end
        endcase

        // Faults are counted in every build; only auto-recovery lets the
        // count steer the unit back through a recovery reset.
        if (w_fault) begin
            w_cnt_nxt = '0;
            if (r_retries < c_MAX_RETRIES) begin
                w_retries_nxt = r_retries + 1'b1;
`ifdef FAILOVER_AUTO_RECOVER_EN
                w_state_nxt   = ST_RESETTING;
`else
                w_state_nxt   = ST_LOCKED;
`endif
            end else begin
                w_state_nxt   = ST_LOCKED;
            end
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_WAIT_UP;
            r_cnt      <= '0;
            r_retries  <= '0;
            unit_reset <= 1'b0;
            ready      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_retries  <= w_retries_nxt;
            unit_reset <= (w_state_nxt == ST_RESETTING);
            ready      <= (w_state_nxt == ST_READY);
            locked     <= (w_state_nxt == ST_LOCKED);
        end
    end

endmodule
`default_nettype wire

// File: rtl/failover_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : failover_ctrl
// Description : Three-unit redundancy controller. One unit_recovery per unit
//               plus a non-preemptive active-unit selector with a one-cycle
//               switch event on every selection change.
//               Config macro FAILOVER_AUTO_RECOVER_EN (see unit_recovery).
// Revision    : 1.0 - initial release
// ============================================================================
module failover_ctrl
    import fdu_pkg::*;
#(
    parameter int unsigned HOLDOFF      = 1000,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned UP_TIMEOUT   = 13000000,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_UNITS-1:0] health,
    input  logic [N_UNITS-1:0] lock_clear,
    output logic [N_UNITS-1:0] unit_reset,
    output logic [N_UNITS-1:0] ready,
    output logic [N_UNITS-1:0] locked,
    output logic [SEL_W-1:0]   active_sel,
    output logic               active_valid,
    output logic               switch_evt
);

    logic [SEL_W-1:0] r_active_sel;
    logic             r_active_valid;
    logic             r_switch_evt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_valid_nxt;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
            unit_recovery #(
                .HOLDOFF      (HOLDOFF),
                .RESET_CYCLES (RESET_CYCLES),
                .UP_TIMEOUT   (UP_TIMEOUT),
                .MAX_RETRIES  (MAX_RETRIES)
            ) u_unit (
                .clk        (clk),
                .reset      (reset),
                .health     (health[gi]),
                .lock_clear (lock_clear[gi]),
                .unit_reset (unit_reset[gi]),
                .ready      (ready[gi]),
                .locked     (locked[gi])
            );
        end
    endgenerate

    // Re-select only when nothing is active or the active unit lost ready
    always_comb begin
        w_sel_nxt   = r_active_sel;
        w_valid_nxt = r_active_valid;
        if (!r_active_valid || !ready[r_active_sel]) begin
            if (|ready) begin
                w_sel_nxt   = lowest_set(ready);
                w_valid_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    // Selection registers and the change pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_sel   <= '0;
            r_active_valid <= 1'b0;
            r_switch_evt   <= 1'b0;
        end else begin
            r_active_sel   <= w_sel_nxt;
            r_active_valid <= w_valid_nxt;
            r_switch_evt   <= (w_sel_nxt != r_active_sel) || (w_valid_nxt != r_active_valid);
        end
    end

    assign active_sel   = r_active_sel;
    assign active_valid = r_active_valid;
    assign switch_evt   = r_switch_evt;

endmodule
`default_nettype wire
